// File: rtl/bus_fabric.sv
// CPU-side interconnect: decodes memory / register-space slots / internal status regs,
// gates strobes to the selected target and aborts accesses stalled beyond TIMEOUT cycles.
module bus_fabric #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SLOT_BITS = 4,
  parameter logic [7:0]  REG_PAGE  = 8'hFF,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_W-1:0]             cpu_address,
  input  logic [DATA_W-1:0]             cpu_data_out,
  output logic [DATA_W-1:0]             cpu_data_in,
  input  logic                          cpu_read,
  input  logic                          cpu_write,
  output logic                          cpu_wait,
  output logic                          mem_read,
  output logic                          mem_write,
  input  logic [DATA_W-1:0]             mem_data_in,
  input  logic                          mem_wait,
  output logic [NUM_SLOTS-1:0]          slot_read,
  output logic [NUM_SLOTS-1:0]          slot_write,
  input  logic [NUM_SLOTS*DATA_W-1:0]   slot_data_in,
  input  logic [NUM_SLOTS-1:0]          slot_wait,
  output logic                          bus_error
);
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned IDX_W = 8 - SLOT_BITS;

  typedef enum logic [1:0] {IDLE, ACCESS, ABORT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             abort_entry, clr_status;
  logic [7:0]       abort_hi, abort_lo;
  logic             sticky, abort_wr;
  logic [3:0]       abort_tgt;
  logic [7:0]       status;

  // Write data only matters to targets wired outside this block; internal regs ignore it.
  logic unused;
  assign unused = ^cpu_data_out;

  logic [7:0]       page, low;
  logic [IDX_W-1:0] slot_idx;
  logic             is_reg, is_int, is_slot, is_mem;
  logic             active, rd, wr, sel_wait;

  assign page     = cpu_address[ADDR_W-1 -: 8];
  assign low      = cpu_address[7:0];
  assign slot_idx = low[7:SLOT_BITS];
  assign is_reg   = (page == REG_PAGE);
  assign is_mem   = !is_reg;
  assign is_int   = is_reg && (low >= 8'hFD);
  assign is_slot  = is_reg && !is_int && (32'(slot_idx) < NUM_SLOTS);
  assign active   = cpu_read | cpu_write;
  assign wr       = cpu_write;
  assign rd       = cpu_read & ~cpu_write;
  assign status   = {sticky, abort_wr, 2'b00, abort_tgt};

  always_comb begin
    sel_wait = 1'b0;
    if (is_mem) sel_wait = mem_wait;
    for (int k = 0; k < int'(NUM_SLOTS); k++) begin
      if (is_slot && slot_idx == IDX_W'(k)) sel_wait = slot_wait[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and watchdog counter; the counter only runs while the selected target stalls.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = '0;
    abort_entry = 1'b0;
    case (state)
      IDLE, ACCESS: begin
        if (active) begin
          state_nxt = ACCESS;
          if (sel_wait) begin
            if ((TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT))) begin
              state_nxt   = ABORT;
              abort_entry = 1'b1;
            end else if (cnt != {CNT_W{1'b1}}) begin
              cnt_nxt = cnt + CNT_W'(1);
            end else begin
              cnt_nxt = cnt;
            end
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      ABORT:   if (!active) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_status = active && (state != ABORT) && wr && is_int && (low == 8'hFF);

  // Abort capture; a capture in the same cycle as a clear keeps the error set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_hi  <= '0;
      abort_lo  <= '0;
      sticky    <= 1'b0;
      abort_wr  <= 1'b0;
      abort_tgt <= '0;
      bus_error <= 1'b0;
    end else begin
      bus_error <= abort_entry;
      if (abort_entry) begin
        abort_hi  <= page;
        abort_lo  <= low;
        sticky    <= 1'b1;
        abort_wr  <= wr;
        abort_tgt <= is_mem ? 4'hF : 4'(slot_idx);
      end else if (clr_status) begin
        sticky <= 1'b0;
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(abort_entry && clr_status));

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    slot_read   = '0;
    slot_write  = '0;
    cpu_wait    = 1'b0;
    cpu_data_in = '0;
    if (active && state == ABORT) begin
      cpu_data_in = DATA_W'(8'hFF);
    end else if (active) begin
      cpu_wait  = sel_wait;
      mem_read  = is_mem & rd;
      mem_write = is_mem & wr;
      if (rd && is_mem) cpu_data_in = mem_data_in;
      for (int k = 0; k < int'(NUM_SLOTS); k++) begin
        if (is_slot && slot_idx == IDX_W'(k)) begin
          slot_read[k]  = rd;
          slot_write[k] = wr;
          if (rd) cpu_data_in = slot_data_in[k*DATA_W +: DATA_W];
        end
      end
      if (rd && is_int) begin
        case (low)
          8'hFD:   cpu_data_in = DATA_W'(abort_hi);
          8'hFE:   cpu_data_in = DATA_W'(abort_lo);
          default: cpu_data_in = DATA_W'(status);
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: directed scenarios plus randomized accesses
// compared cycle by cycle against an address-map / status-register model.
module tb_bus_fabric;
  localparam int unsigned TO = 8;
  localparam int MEM  = -1;
  localparam int UNM  = -2;
  localparam int INTR = -3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_address = '0;
  logic [7:0]  cpu_data_out = '0;
  logic [7:0]  cpu_data_in;
  logic        cpu_read = 1'b0, cpu_write = 1'b0, cpu_wait;
  logic        mem_read, mem_write;
  logic [7:0]  mem_data_in = '0;
  logic        mem_wait = 1'b0;
  logic [3:0]  slot_read, slot_write;
  logic [31:0] slot_data_in = '0;
  logic [3:0]  slot_wait = '0;
  logic        bus_error;

  always #5 clk = ~clk;

  bus_fabric #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_address(cpu_address), .cpu_data_out(cpu_data_out),
    .cpu_data_in(cpu_data_in), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_wait(cpu_wait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_data_in(mem_data_in), .mem_wait(mem_wait),
    .slot_read(slot_read), .slot_write(slot_write), .slot_data_in(slot_data_in),
    .slot_wait(slot_wait), .bus_error(bus_error)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Software-visible status model
  logic [7:0] m_hi = '0, m_lo = '0;
  logic       m_sticky = 1'b0, m_wr = 1'b0;
  logic [3:0] m_tgt = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int target_of(input logic [15:0] a);
    int lo;
    lo = int'(a) % 256;
    if (int'(a) / 256 != 255) return MEM;
    if (lo >= 253) return INTR;
    if (lo / 16 < 4) return lo / 16;
    return UNM;
  endfunction

  function automatic logic [7:0] int_read(input logic [15:0] a);
    int lo;
    lo = int'(a) % 256;
    if (lo == 253) return m_hi;
    if (lo == 254) return m_lo;
    return {m_sticky, m_wr, 2'b00, m_tgt};
  endfunction

  task automatic randomize_side_inputs();
    mem_wait     = 1'($urandom);
    slot_wait    = 4'($urandom);
    mem_data_in  = 8'($urandom);
    slot_data_in = $urandom;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_address = 16'($urandom);
    randomize_side_inputs();
    @(negedge clk);
    check("idle_strobes", 32'({mem_read, mem_write, slot_read, slot_write}), 32'(0));
    check("idle_wait", 32'(cpu_wait), 32'(0));
    check("idle_data", 32'(cpu_data_in), 32'(0));
    check("idle_bus_error", 32'(bus_error), 32'(0));
  endtask

  // One CPU access; the selected target stalls for its first wlen cycles.
  task automatic access(input logic [15:0] a, input bit w, input bit both, input int wlen,
                        input logic [7:0] wdata, input logic [7:0] rdata, output bit aborted);
    int tgt, c;
    bit stall, r, done, ab, ew;
    logic [9:0] es;
    logic [7:0] ed;
    tgt = target_of(a);
    stall = (tgt == MEM) || (tgt >= 0);
    r = !w;
    c = 0;
    done = 1'b0;
    aborted = 1'b0;
    while (!done) begin
      c++;
      @(posedge clk); #1;
      cpu_address = a;
      cpu_write = w;
      cpu_read = !w || both;
      cpu_data_out = wdata;
      randomize_side_inputs();
      if (tgt == MEM) begin
        mem_wait = (c <= wlen);
        mem_data_in = rdata;
      end else if (tgt >= 0) begin
        slot_wait[tgt] = (c <= wlen);
        slot_data_in[tgt*8 +: 8] = rdata;
      end
      ab = stall && (c == int'(TO) + 2);
      ew = stall && !ab && (c <= wlen);
      @(negedge clk);
      es = '0;
      if (!ab) begin
        if (tgt == MEM) es[9:8] = {r, w};
        else if (tgt >= 0) begin
          es[4+tgt] = r;
          es[tgt] = w;
        end
      end
      check("strobes", 32'({mem_read, mem_write, slot_read, slot_write}), 32'(es));
      check("bus_error", 32'(bus_error), 32'(ab));
      check("cpu_wait", 32'(cpu_wait), 32'(ew));
      if (!ew) begin
        done = 1'b1;
        ed = 8'h00;
        if (ab) ed = 8'hFF;
        else if (tgt == MEM || tgt >= 0) ed = rdata;
        else if (tgt == INTR) ed = int_read(a);
        if (ab || r) check(ab ? "abort_data" : "read_data", 32'(cpu_data_in), 32'(ed));
      end
    end
    if (ab) begin
      aborted = 1'b1;
      m_hi = a[15:8];
      m_lo = a[7:0];
      m_sticky = 1'b1;
      m_wr = w;
      m_tgt = (tgt == MEM) ? 4'hF : 4'(tgt);
    end else if (w && a == 16'hFFFF) begin
      m_sticky = 1'b0;
    end
  endtask

  initial begin
    bit ab;
    logic [15:0] a;
    bit w, both;
    int wlen, cls, pick;

    // Reset state
    idle_cycle();
    idle_cycle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycle();
    access(16'hFFFF, 1'b0, 1'b0, 0, 8'h00, 8'h00, ab);
    access(16'hFFFE, 1'b0, 1'b0, 0, 8'h00, 8'h00, ab);
    access(16'hFFFD, 1'b0, 1'b0, 0, 8'h00, 8'h00, ab);
    idle_cycle();

    // Memory read with three stall cycles
    access(16'h1234, 1'b0, 1'b0, 3, 8'h00, 8'hA5, ab);
    idle_cycle();
    // Slot 2 write, then unmapped read back to back
    access(16'hFF25, 1'b1, 1'b0, 0, 8'h5A, 8'h00, ab);
    access(16'hFFE0, 1'b0, 1'b0, 0, 8'h00, 8'h77, ab);
    idle_cycle();

    // Slot 1 stuck -> abort
    access(16'hFF10, 1'b0, 1'b0, 50, 8'h00, 8'h33, ab);
    check("abort_seen", 32'(ab), 32'(1));
    idle_cycle();
    access(16'hFFFF, 1'b0, 1'b0, 0, 8'h00, 8'h00, ab);
    access(16'hFFFE, 1'b0, 1'b0, 0, 8'h00, 8'h00, ab);
    access(16'hFFFD, 1'b0, 1'b0, 0, 8'h00, 8'h00, ab);
    check("status_model", 32'({m_sticky, m_wr, 2'b00, m_tgt}), 32'(8'h81));
    access(16'hFFFF, 1'b1, 1'b0, 0, 8'h00, 8'h00, ab);
    access(16'hFFFF, 1'b0, 1'b0, 0, 8'h00, 8'h00, ab);
    idle_cycle();

    // Watchdog boundary: TIMEOUT stall cycles complete, one more aborts
    access(16'h0800, 1'b0, 1'b0, int'(TO), 8'h00, 8'h3C, ab);
    check("no_abort_at_limit", 32'(ab), 32'(0));
    access(16'hFF30, 1'b1, 1'b1, int'(TO) + 1, 8'hC3, 8'h00, ab);
    check("abort_past_limit", 32'(ab), 32'(1));
    idle_cycle();
    access(16'hFFFF, 1'b0, 1'b0, 0, 8'h00, 8'h00, ab);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      cls = int'($urandom_range(0, 9));
      if (cls < 3)      a = {8'($urandom_range(0, 254)), 8'($urandom)};
      else if (cls < 6) a = {8'hFF, 4'($urandom_range(0, 3)), 4'($urandom)};
      else if (cls < 7) a = {8'hFF, 8'($urandom_range(64, 252))};
      else              a = {8'hFF, 8'($urandom_range(253, 255))};
      w = ($urandom_range(0, 2) == 0);
      both = 1'($urandom);
      pick = int'($urandom_range(0, 9));
      if (pick < 7)      wlen = int'($urandom_range(0, 3));
      else if (pick < 9) wlen = int'(TO);
      else               wlen = int'(TO) + 1 + int'($urandom_range(0, 3));
      access(a, w, both, wlen, 8'($urandom), 8'($urandom), ab);
      if (ab || $urandom_range(0, 1) == 0) idle_cycle();
    end

    // Reset in the middle of a stalled access
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      cpu_address = 16'h4000;
      cpu_read = 1'b1;
      cpu_write = 1'b0;
      mem_wait = 1'b1;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    cpu_read = 1'b0;
    mem_wait = 1'b0;
    @(negedge clk);
    check("rst_strobes", 32'({mem_read, mem_write, slot_read, slot_write}), 32'(0));
    check("rst_wait", 32'(cpu_wait), 32'(0));
    check("rst_bus_error", 32'(bus_error), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0; m_sticky = 1'b0; m_wr = 1'b0; m_tgt = '0;
    access(16'hFFFF, 1'b0, 1'b0, 0, 8'h00, 8'h00, ab);
    access(16'hFFFE, 1'b0, 1'b0, 0, 8'h00, 8'h00, ab);
    access(16'h4000, 1'b0, 1'b0, int'(TO), 8'h00, 8'h96, ab);
    check("counter_cleared_by_reset", 32'(ab), 32'(0));
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
